vec_unpack: RTL and testbench

//  Parametrised vector separator for the accelerator input path. It takes a densely packed
//  AXI-stream of VECTOR_WIDTH-bit vectors carried on BUS_WIDTH-bit words. Each vector is

---
 rtl/vec_unpack.sv | 143 ++++++++++++++
 tb/tb_vec_unpack.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_unpack.sv
// rtl/vec_unpack.sv - splits a densely packed vector stream into MSB-aligned, zero-padded sub-word beats
module vec_unpack #(
    parameter int BUS_WIDTH          = 128,
    parameter int VECTOR_WIDTH       = 920,
    parameter int VEC_ID_WIDTH       = 8,
    parameter bit REVERSE_BITS       = 1'b1,
    parameter bit ID_RESET_ON_LAST   = 1'b1,
    localparam int SUB_VEC_NO        = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int SIDX_W            = $clog2(SUB_VEC_NO) + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BUS_WIDTH-1:0]    up_Vector,
    input  logic                    up_Valid,
    input  logic                    up_Last,
    output logic                    up_Ready,
    output logic [BUS_WIDTH-1:0]    dn_Vector,
    output logic [VEC_ID_WIDTH-1:0] dn_VecID,
    output logic [SIDX_W-1:0]       dn_SubIdx,
    output logic                    dn_Valid,
    output logic                    dn_Last,
    input  logic                    dn_Ready,
    output logic                    err_Trunc
);

    localparam int          FILL_W   = $clog2(2 * BUS_WIDTH + 1);
    localparam logic [31:0] BW       = 32'(BUS_WIDTH);
    localparam logic [31:0] VW       = 32'(VECTOR_WIDTH);
    localparam logic [31:0] RW       = 32'(VECTOR_WIDTH - (SUB_VEC_NO - 1) * BUS_WIDTH);
    localparam logic [SIDX_W-1:0] LAST_SUB = SIDX_W'(SUB_VEC_NO - 1);

    logic [2*BUS_WIDTH-1:0]  r_acc;
    logic [FILL_W-1:0]       r_fill;
    logic                    r_last_seen;
    logic [SIDX_W-1:0]       r_sub;
    logic [VEC_ID_WIDTH-1:0] r_id;
    logic                    r_err;
    logic                    r_stall;
    logic                    r_stall_last;

    logic [BUS_WIDTH-1:0]    w_word;
    logic [BUS_WIDTH-1:0]    w_mask;
    logic [31:0]             w_fill;
    logic [31:0]             w_need;
    logic [31:0]             w_pop_bits;
    logic [31:0]             w_fill_after;
    logic [31:0]             w_fill_next;
    logic [2*BUS_WIDTH-1:0]  w_acc_next;
    logic [VEC_ID_WIDTH-1:0] w_id_inc;
    logic                    w_final;
    logic                    w_disc;
    logic                    w_trunc;
    logic                    w_hold;
    logic                    w_valid;
    logic                    w_last_now;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_end;

    always_comb begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            w_word[i] = REVERSE_BITS ? up_Vector[BUS_WIDTH-1-i] : up_Vector[i];
        end
    end

    always_comb begin
        w_fill     = 32'(r_fill);
        w_final    = (r_sub == LAST_SUB);
        w_need     = w_final ? RW : BW;
        w_disc     = r_last_seen && (r_sub == '0) && (w_fill < VW);
        w_trunc    = r_last_seen && (r_sub != '0) && (w_fill < w_need);
        // Holding an exactly-filled final beat until more input or the batch end is seen
        // means dn_Last is always correct on the first cycle the beat is shown.
        w_hold     = w_final && (w_fill == w_need) && !r_last_seen;
        w_valid    = w_trunc || ((w_fill >= w_need) && !w_hold && !w_disc);
        w_last_now = w_trunc || (w_final && r_last_seen && ((w_fill - w_need) < VW));
        w_mask     = ~({BUS_WIDTH{1'b1}} >> w_need);
    end

    assign up_Ready  = (w_fill <= BW) && !r_last_seen;
    assign dn_Valid  = w_valid;
    // A stalled beat keeps the dn_Last it was first presented with, even if the batch end arrives meanwhile.
    assign dn_Last   = r_stall ? r_stall_last : w_last_now;
    assign dn_Vector = r_acc[2*BUS_WIDTH-1 -: BUS_WIDTH] & w_mask;
    assign dn_VecID  = r_id;
    assign dn_SubIdx = r_sub;
    assign err_Trunc = r_err;

    always_comb begin
        w_push       = up_Valid && up_Ready;
        w_pop        = w_valid && dn_Ready;
        w_end        = w_pop && dn_Last;
        w_pop_bits   = w_pop ? w_need : 32'd0;
        w_fill_after = w_fill - w_pop_bits;
        w_fill_next  = w_fill_after + (w_push ? BW : 32'd0);
        w_acc_next   = (r_acc << w_pop_bits) |
                       (w_push ? ({w_word, {BUS_WIDTH{1'b0}}} >> w_fill_after) : '0);
        w_id_inc     = r_id + VEC_ID_WIDTH'(1);
        if (w_id_inc == '0) begin
            w_id_inc = VEC_ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_last_seen  <= 1'b0;
            r_sub        <= '0;
            r_id         <= VEC_ID_WIDTH'(1);
            r_err        <= 1'b0;
            r_stall      <= 1'b0;
            r_stall_last <= 1'b0;
        end else begin
            r_stall      <= w_valid && !dn_Ready;
            r_stall_last <= dn_Last;
            if (w_disc || w_end) begin
                r_acc       <= '0;
                r_fill      <= '0;
                r_last_seen <= 1'b0;
                r_sub       <= '0;
            end else begin
                r_acc  <= w_acc_next;
                r_fill <= FILL_W'(w_fill_next);
                if (w_push && up_Last) begin
                    r_last_seen <= 1'b1;
                end
                if (w_pop) begin
                    r_sub <= w_final ? '0 : r_sub + SIDX_W'(1);
                end
            end
            if (w_end) begin
                r_id <= ID_RESET_ON_LAST ? VEC_ID_WIDTH'(1) : w_id_inc;
            end else if (w_pop && w_final) begin
                r_id <= w_id_inc;
            end
            if (w_pop && w_trunc) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_unpack.sv
// tb/tb_vec_unpack.sv - scoreboard bench for vec_unpack across three parameter sets
module tb_vec_unpack;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   id;
        logic [3:0]   sub;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] up_vector;
    logic         up_valid;
    logic         up_last;
    logic         dn_ready;
    int           sel;
    bit           tog;
    int           checks = 0;
    int           errors = 0;
    beat_t        exp_q[$];
    logic [127:0] w [8];
    logic [1023:0] big;

    always #5 clk = ~clk;

    logic         a_up_ready, a_dn_valid, a_dn_last, a_err;
    logic [127:0] a_dn_vector;
    logic [7:0]   a_id;
    logic [1:0]   a_sub;
    logic         b_up_ready, b_dn_valid, b_dn_last, b_err;
    logic [127:0] b_dn_vector;
    logic [1:0]   b_id;
    logic [1:0]   b_sub;
    logic         c_up_ready, c_dn_valid, c_dn_last, c_err;
    logic [127:0] c_dn_vector;
    logic [7:0]   c_id;
    logic [2:0]   c_sub;

    vec_unpack #(.BUS_WIDTH(128), .VECTOR_WIDTH(200), .VEC_ID_WIDTH(8),
                 .REVERSE_BITS(1'b0), .ID_RESET_ON_LAST(1'b1)) u_a (
        .clk(clk), .rstn(rstn), .up_Vector(up_vector), .up_Valid(up_valid && sel == 0),
        .up_Last(up_last), .up_Ready(a_up_ready), .dn_Vector(a_dn_vector), .dn_VecID(a_id),
        .dn_SubIdx(a_sub), .dn_Valid(a_dn_valid), .dn_Last(a_dn_last), .dn_Ready(dn_ready),
        .err_Trunc(a_err));

    vec_unpack #(.BUS_WIDTH(128), .VECTOR_WIDTH(256), .VEC_ID_WIDTH(2),
                 .REVERSE_BITS(1'b0), .ID_RESET_ON_LAST(1'b0)) u_b (
        .clk(clk), .rstn(rstn), .up_Vector(up_vector), .up_Valid(up_valid && sel == 1),
        .up_Last(up_last), .up_Ready(b_up_ready), .dn_Vector(b_dn_vector), .dn_VecID(b_id),
        .dn_SubIdx(b_sub), .dn_Valid(b_dn_valid), .dn_Last(b_dn_last), .dn_Ready(dn_ready),
        .err_Trunc(b_err));

    vec_unpack #(.BUS_WIDTH(128), .VECTOR_WIDTH(300), .VEC_ID_WIDTH(8),
                 .REVERSE_BITS(1'b1), .ID_RESET_ON_LAST(1'b1)) u_c (
        .clk(clk), .rstn(rstn), .up_Vector(up_vector), .up_Valid(up_valid && sel == 2),
        .up_Last(up_last), .up_Ready(c_up_ready), .dn_Vector(c_dn_vector), .dn_VecID(c_id),
        .dn_SubIdx(c_sub), .dn_Valid(c_dn_valid), .dn_Last(c_dn_last), .dn_Ready(dn_ready),
        .err_Trunc(c_err));

    logic         m_valid, m_last, m_up_ready;
    logic [127:0] m_vector;
    logic [7:0]   m_id;
    logic [3:0]   m_sub;

    always_comb begin
        m_valid = a_dn_valid; m_last = a_dn_last; m_up_ready = a_up_ready;
        m_vector = a_dn_vector; m_id = a_id; m_sub = {2'b00, a_sub};
        if (sel == 1) begin
            m_valid = b_dn_valid; m_last = b_dn_last; m_up_ready = b_up_ready;
            m_vector = b_dn_vector; m_id = {6'b0, b_id}; m_sub = {2'b00, b_sub};
        end else if (sel == 2) begin
            m_valid = c_dn_valid; m_last = c_dn_last; m_up_ready = c_up_ready;
            m_vector = c_dn_vector; m_id = c_id; m_sub = {1'b0, c_sub};
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic [127:0] d, input logic [7:0] id, input logic [3:0] sub,
                            input logic last);
        beat_t b;
        b.data = d; b.id = id; b.sub = sub; b.last = last;
        exp_q.push_back(b);
    endtask

    function automatic logic [127:0] chunk(input logic [1023:0] s, input int start, input int n);
        logic [127:0] r = '0;
        for (int j = 0; j < n; j++) r[127-j] = s[1023-start-j];
        return r;
    endfunction

    function automatic logic [127:0] rev128(input logic [127:0] x);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = x[127-j];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send(input logic [127:0] d, input logic l);
        int n = 0;
        up_vector = d; up_last = l; up_valid = 1'b1;
        while (!m_up_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: up_Ready low for %0d cycles, expected acceptance", n);
        end
        @(negedge clk);
        up_valid = 1'b0; up_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic batch_a();
        for (int k = 0; k < 5; k++) begin
            exp_push(chunk(big, k * 200, 128), 8'(k + 1), 4'd0, 1'b0);
            exp_push(chunk(big, k * 200 + 128, 72), 8'(k + 1), 4'd1, k == 4);
        end
        for (int i = 0; i < 8; i++) send(w[i], i == 7);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (tog) dn_ready = !dn_ready;
        end
    end

    initial begin
        beat_t        e;
        bit           st = 1'b0;
        logic [127:0] sv_vec;
        logic [7:0]   sv_id;
        logic [3:0]   sv_sub;
        logic         sv_last;
        int           mfill = 0;
        bit           mls = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                st = 1'b0; mfill = 0; mls = 1'b0;
            end else begin
                if (st) begin
                    chk("stall_valid", 128'(m_valid), 128'(1));
                    chk("stall_vector", m_vector, sv_vec);
                    chk("stall_id", 128'(m_id), 128'(sv_id));
                    chk("stall_sub", 128'(m_sub), 128'(sv_sub));
                    chk("stall_last", 128'(m_last), 128'(sv_last));
                end
                if (sel == 0) begin
                    chk("up_ready_vs_fill", 128'(m_up_ready), 128'((mfill <= 128) && !mls));
                    if (up_valid && m_up_ready) begin
                        mfill += 128;
                        if (up_last) mls = 1'b1;
                    end
                end
                if (m_valid && dn_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got data %h id %0d sub %0d, expected none",
                                 m_vector, m_id, m_sub);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_vector, e.data);
                        chk("beat_id", 128'(m_id), 128'(e.id));
                        chk("beat_sub", 128'(m_sub), 128'(e.sub));
                        chk("beat_last", 128'(m_last), 128'(e.last));
                    end
                    if (sel == 0) begin
                        if (m_last) begin
                            mfill = 0; mls = 1'b0;
                        end else begin
                            mfill -= (m_sub == 4'd1) ? 72 : 128;
                        end
                    end
                    st = 1'b0;
                end else if (m_valid) begin
                    st = 1'b1; sv_vec = m_vector; sv_id = m_id; sv_sub = m_sub; sv_last = m_last;
                end else begin
                    st = 1'b0;
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; up_valid = 1'b0; up_last = 1'b0; up_vector = '0;
        dn_ready = 1'b1; sel = 0; tog = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = {32'hDEADBEEF ^ (32'(i) * 32'h11111111), 32'h01234567 + 32'(i),
                    32'h89ABCDEF - 32'(i), 24'hC0FFEE, 8'(i)};
            big[1023 - 128 * i -: 128] = w[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(a_dn_valid), 128'(0));
        chk("rst_last", 128'(a_dn_last), 128'(0));
        chk("rst_vector", a_dn_vector, 128'(0));
        chk("rst_id", 128'(a_id), 128'(1));
        chk("rst_sub", 128'(a_sub), 128'(0));
        chk("rst_up_ready", 128'(a_up_ready), 128'(1));
        chk("rst_err", 128'(c_err), 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        batch_a();
        wait_drain();
        chk("a_idle_valid", 128'(a_dn_valid), 128'(0));
        chk("a_idle_up_ready", 128'(a_up_ready), 128'(1));

        tog = 1'b1;
        batch_a();
        wait_drain();
        tog = 1'b0;
        @(negedge clk);
        dn_ready = 1'b1;

        sel = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_push(w[i], 8'(i / 2 + 1), 4'(i % 2), i == 5);
        for (int i = 0; i < 4; i++) send(w[i], 1'b0);
        repeat (4) @(negedge clk);
        chk("b_hold_valid", 128'(m_valid), 128'(0));
        chk("b_hold_sub", 128'(m_sub), 128'(1));
        chk("b_hold_id", 128'(m_id), 128'(2));
        send(w[4], 1'b0);
        send(w[5], 1'b1);
        wait_drain();
        exp_push(w[6], 8'd1, 4'd0, 1'b0);
        exp_push(w[7], 8'd1, 4'd1, 1'b1);
        send(w[6], 1'b0);
        send(w[7], 1'b1);
        wait_drain();

        sel = 2;
        @(negedge clk);
        exp_push(rev128(w[0]), 8'd1, 4'd0, 1'b0);
        exp_push(rev128(w[1]), 8'd1, 4'd1, 1'b0);
        exp_push(128'(0), 8'd1, 4'd2, 1'b1);
        send(w[0], 1'b0);
        send(w[1], 1'b1);
        wait_drain();
        chk("c_trunc_set", 128'(c_err), 128'(1));
        repeat (5) @(negedge clk);
        chk("c_trunc_sticky", 128'(c_err), 128'(1));
        chk("c_id_after_batch", 128'(c_id), 128'(1));

        sel = 0;
        dn_ready = 1'b0;
        send(w[0], 1'b0);
        send(w[1], 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_valid", 128'(a_dn_valid), 128'(0));
        chk("midrst_up_ready", 128'(a_up_ready), 128'(1));
        chk("midrst_id", 128'(a_id), 128'(1));
        chk("midrst_sub", 128'(a_sub), 128'(0));
        chk("midrst_err", 128'(c_err), 128'(0));
        repeat (3) @(negedge clk);
        chk("midrst_no_beat", 128'(a_dn_valid), 128'(0));
        dn_ready = 1'b1;
        batch_a();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
